// File: rtl/posit_seq_pkg.sv
// Shared definitions for the posit coprocessor sequencer: FSM states,
// opcode encodings and register window offsets.
package posit_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WT_A,
    ST_WR_B,
    ST_WT_B,
    ST_WR_OP,
    ST_WT_OP,
    ST_SETTLE,
    ST_RD,
    ST_WT_RD,
    ST_RESP
  } state_e;

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;

  localparam logic [31:0] OFF_A  = 32'd0;
  localparam logic [31:0] OFF_B  = 32'd8;
  localparam logic [31:0] OFF_OP = 32'd16;

  localparam logic [3:0] BE_ALL = 4'hF;

  // Only ADD, MUL and DIV are understood by the coprocessor.
  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/posit_seq_master.sv
// Sequences one posit operation on the coprocessor bus: write A, write B,
// write the opcode, wait a settle period, read the result, then hand the
// result (or an error) back on the response channel.
module posit_seq_master
  import posit_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          TIMEOUT   = 16,
  parameter int          SETTLE    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_op_i,
  input  logic [31:0] cmd_a_i,
  input  logic [31:0] cmd_b_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [15:0] WAIT_LAST   = 16'(TIMEOUT - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic        wait_expired;

  // The same counter serves the response wait in WT_* and the settle delay.
  assign wait_expired = (cnt_q == WAIT_LAST);

  assign rsp_data_o = data_q;
  assign rsp_err_o  = err_q;

  // Next-state, bus request and handshake decode.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    err_d       = err_q;
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_be_o    = 4'h0;
    bus_addr_o  = 32'h0;
    bus_wdata_o = 32'h0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          op_d  = cmd_op_i;
          a_d   = cmd_a_i;
          b_d   = cmd_b_i;
          cnt_d = 16'd0;
          if (op_legal(cmd_op_i)) begin
            state_d = ST_WR_A;
          end else begin
            data_d  = 32'h0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_WR_A: begin
        bus_req_o   = 1'b1;
        bus_we_o    = 1'b1;
        bus_be_o    = BE_ALL;
        bus_addr_o  = BASE_ADDR + OFF_A;
        bus_wdata_o = a_q;
        cnt_d       = 16'd0;
        state_d     = ST_WT_A;
      end
      ST_WR_B: begin
        bus_req_o   = 1'b1;
        bus_we_o    = 1'b1;
        bus_be_o    = BE_ALL;
        bus_addr_o  = BASE_ADDR + OFF_B;
        bus_wdata_o = b_q;
        cnt_d       = 16'd0;
        state_d     = ST_WT_B;
      end
      ST_WR_OP: begin
        bus_req_o   = 1'b1;
        bus_we_o    = 1'b1;
        bus_be_o    = BE_ALL;
        bus_addr_o  = BASE_ADDR + OFF_OP;
        bus_wdata_o = {29'd0, op_q};
        cnt_d       = 16'd0;
        state_d     = ST_WT_OP;
      end
      ST_RD: begin
        bus_req_o  = 1'b1;
        bus_be_o   = BE_ALL;
        bus_addr_o = BASE_ADDR + OFF_OP;
        cnt_d      = 16'd0;
        state_d    = ST_WT_RD;
      end
      ST_WT_A, ST_WT_B, ST_WT_OP, ST_WT_RD: begin
        if (bus_rvalid_i) begin
          cnt_d = 16'd0;
          case (state_q)
            ST_WT_A:  state_d = ST_WR_B;
            ST_WT_B:  state_d = ST_WR_OP;
            ST_WT_OP: state_d = (SETTLE == 0) ? ST_RD : ST_SETTLE;
            default: begin
              data_d  = bus_rdata_i;
              err_d   = 1'b0;
              state_d = ST_RESP;
            end
          endcase
        end else if (wait_expired) begin
          data_d  = 32'h0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_RD;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any transaction in flight.
  always_ff @(posedge clk_i) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= 3'd0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      cnt_q   <= 16'd0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/posit_seq_master.md
POSIT_SEQ_MASTER -- requirements
Module: posit_seq_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0, bus base address of the posit coprocessor register window.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum cycles to wait for bus_rvalid_i per access.
REQ-003 SHALL have parameter SETTLE, default 2, idle cycles between the op write and the result read.
REQ-004 SHALL have port clk_i, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port cmd_valid_i, input, 1, command offered.
REQ-007 SHALL have port cmd_ready_o, output, 1, command accepted when valid&ready.
REQ-008 SHALL have port cmd_op_i, input, 3, opcode (1 ADD, 2 MUL, 3 DIV).
REQ-009 SHALL have ports cmd_a_i and cmd_b_i, input, 32 each, posit operands.
REQ-010 SHALL have port rsp_valid_o, output, 1, result available.
REQ-011 SHALL have port rsp_ready_i, input, 1, result consumed when valid&ready.
REQ-012 SHALL have port rsp_data_o, output, 32, posit result.
REQ-013 SHALL have port rsp_err_o, output, 1, timeout or illegal opcode.
REQ-014 SHALL have ports bus_req_o (1), bus_we_o (1), bus_be_o (4), bus_addr_o (32) and bus_wdata_o (32), all outputs, initiator request.
REQ-015 SHALL have ports bus_rvalid_i (1) and bus_rdata_i (32), inputs, responder reply.

Function
REQ-016 SHALL implement FSM states IDLE, WR_A, WT_A, WR_B, WT_B, WR_OP, WT_OP, SETTLE, RD, WT_RD, RESP.
REQ-017 SHALL assert cmd_ready_o only in IDLE; on handshake, latch op/a/b and go to WR_A.
REQ-018 SHALL, in IDLE, return an illegal opcode (0, 4-7) with rsp_err_o=1 and rsp_data_o=0 via RESP, with no bus traffic.
REQ-019 SHALL drive bus_req_o high for exactly one cycle in each WR_*/RD state, then move to the matching WT_* state.
REQ-020 SHALL use addresses BASE_ADDR+0 for A, +8 for B, and +16 for both the op write and the result read.
REQ-021 SHALL drive bus_we_o=1 for writes, 0 for the read, and bus_be_o=4'hF on every request.
REQ-022 SHALL drive bus_wdata_o as: A, B, or zero-extended op for writes; 0 for the read.
REQ-023 SHALL hold all bus outputs at 0 whenever bus_req_o=0.
REQ-024 SHALL, in each WT_* state, advance on bus_rvalid_i; WT_A→WR_B, WT_B→WR_OP, WT_OP→SETTLE, WT_RD→RESP.
REQ-025 SHALL, in WT_RD, capture bus_rdata_i into rsp_data_o on bus_rvalid_i.
REQ-026 SHALL remain in SETTLE for exactly SETTLE cycles, then go to RD.
REQ-027 SHALL count cycles in each WT_* state; if the count reaches TIMEOUT without rvalid, go to RESP with rsp_err_o=1 and rsp_data_o=0.
REQ-028 SHALL ignore bus_rvalid_i outside WT_* states.
REQ-029 SHALL hold rsp_valid_o=1 in RESP until rsp_ready_i; on handshake, return to IDLE in the next cycle.
REQ-030 SHALL keep rsp_data_o and rsp_err_o stable while rsp_valid_o=1.
REQ-031 SHALL accept back-to-back commands, with a minimum gap of 1 cycle in IDLE.
REQ-032 SHALL give a nominal latency, cmd handshake to rsp_valid_o, of 8+SETTLE cycles with single-cycle rvalid.

Reset
REQ-033 SHALL, on rst_i=1 at a clock edge, go to IDLE and zero all outputs except cmd_ready_o, which is 1 after reset.
REQ-034 SHALL abandon any in-flight transaction on reset mid-operation; no response is issued, and a late rvalid after reset is ignored.

Structure
REQ-035 SHALL take state enum, opcode constants (ADD/MUL/DIV) and register offsets (0, 8, 16) from shared package posit_seq_pkg.
REQ-036 SHALL be a single module with no sub-module; timeout and settle counters are inline.

Verification
REQ-037 SHALL verify: ADD a=32'h40000000, b=32'h40000000, responder replies 32'h48000000 → bus sequence A/B/op=1/read at BASE+0/8/16/16, rsp_data_o=32'h48000000, rsp_err_o=0.
REQ-038 SHALL verify: op=5 → no bus_req_o, rsp_err_o=1 and rsp_data_o=0 within 2 cycles.
REQ-039 SHALL verify: responder withholds rvalid on the B write → rsp_err_o=1 exactly TIMEOUT cycles after WT_B entry.
REQ-040 SHALL verify: rsp_ready_i held low 10 cycles → rsp_valid_o and rsp_data_o stable, cmd_ready_o=0 throughout.
REQ-041 SHALL verify: rst_i pulsed during WT_OP → IDLE next cycle, all bus outputs 0, no rsp_valid_o.
REQ-042 SHALL verify: two back-to-back MUL commands → two correct responses in order, with no overlap of bus transactions.
